// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the byte-wise reflected CRC-32 update.
// Contents: CRC32_POLY (normal form), CRC32_INIT, FCS_BYTES, reflect32(),
//           crc32_update_byte() operating on the reflected (LSB-first) register.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam int          FCS_BYTES  = 4;

    // Bit-reverse a 32-bit word; turns the normal-form polynomial into the
    // constant used by the LSB-first shift register.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // One byte of Ethernet CRC-32. The register is kept in reflected form, so
    // the data byte is XORed into the low bits and the register shifts right;
    // this is what "reflected input" means for the wire bit order.
    function automatic logic [31:0] crc32_update_byte(
        input logic [31:0] crc,
        input logic [7:0]  data,
        input logic [31:0] poly
    );
        logic [31:0] rpoly;
        logic [31:0] c;
        rpoly = reflect32(poly);
        c     = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ rpoly) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_engine.sv
// Ethernet CRC-32 state register with byte-wise update.
// Ports: clk, reset (sync, active-high), clear_i (restart at CRC32_INIT after
//        this cycle), en_i/byte_i (fold byte_i into the CRC), crc_o (inverted,
//        reflected CRC including this cycle's byte, i.e. the FCS value).
module eth_crc32_engine
    import eth_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_upd;
    logic [31:0] crc_d;

    // crc_o looks through the current byte so the top can compare the final
    // CRC in the same cycle the last payload byte is folded in.
    always_comb begin
        crc_upd = en_i ? crc32_update_byte(crc_q, byte_i, POLY) : crc_q;
        crc_d   = clear_i ? CRC32_INIT : crc_upd;
        crc_o   = ~crc_upd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/eth_fcs_checker.sv
// Ethernet FCS checker: strips the 4 trailing FCS bytes from an AXI-Stream
// byte stream and flags frames whose CRC-32 or PHY error status is bad.
// Ports: s_axis_* receive stream (tuser = PHY error), m_axis_* payload stream
//        (tuser on tlast = frame bad), o_frame_good/o_frame_bad status pulses.
module eth_fcs_checker
    import eth_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,           // only 8 is supported
    parameter logic [31:0] POLY       = CRC32_POLY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  o_frame_good,
    output logic                  o_frame_bad
);

    // Delay line: dly_q[0] is the oldest byte. Once full, it always holds the
    // next payload byte plus three candidate FCS bytes.
    logic [DATA_WIDTH-1:0] dly_q [FCS_BYTES];
    logic [DATA_WIDTH-1:0] dly_d [FCS_BYTES];
    logic [2:0]            count_q, count_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
    logic                  mvalid_q, mvalid_d;
    logic                  mlast_q, mlast_d;
    logic                  muser_q, muser_d;
    logic                  good_q, good_d;
    logic                  bad_q, bad_d;

    logic                  xfer;
    logic                  full;
    logic                  shift;
    logic                  crc_clear;
    logic [31:0]           crc_fin;
    logic [31:0]           fcs_rx;
    logic                  frame_bad;

    assign full  = (count_q == 3'(FCS_BYTES));
    // Only a full delay line needs the output register; while filling, input
    // is accepted regardless of downstream backpressure.
    assign s_axis_tready = !reset && (!full || !mvalid_q || m_axis_tready);
    assign xfer  = s_axis_tvalid && s_axis_tready;
    assign shift = xfer && full;
    assign crc_clear = xfer && s_axis_tlast;

    eth_crc32_engine #(.POLY(POLY)) u_crc (
        .clk     (clk),
        .reset   (reset),
        .clear_i (crc_clear),
        .en_i    (shift),
        .byte_i  (dly_q[0]),
        .crc_o   (crc_fin)
    );

    // FCS arrives LSB byte first: dly_q[1] is the first FCS byte on the wire.
    assign fcs_rx    = {s_axis_tdata, dly_q[3], dly_q[2], dly_q[1]};
    assign frame_bad = (crc_fin != fcs_rx) || err_q || s_axis_tuser;

    always_comb begin
        count_d  = count_q;
        dly_d    = dly_q;
        err_d    = err_q;
        mdata_d  = mdata_q;
        mlast_d  = mlast_q;
        muser_d  = muser_q;
        mvalid_d = mvalid_q && !m_axis_tready;
        good_d   = 1'b0;
        bad_d    = 1'b0;

        if (xfer) begin
            if (!full) begin
                dly_d[count_q[1:0]] = s_axis_tdata;
                count_d             = count_q + 3'd1;
            end else begin
                for (int i = 0; i < FCS_BYTES - 1; i++) begin
                    dly_d[i] = dly_q[i+1];
                end
                dly_d[FCS_BYTES-1] = s_axis_tdata;
                mvalid_d = 1'b1;
                mdata_d  = dly_q[0];
                mlast_d  = s_axis_tlast;
                muser_d  = s_axis_tlast && frame_bad;
                if (s_axis_tlast) begin
                    good_d = !frame_bad;
                    bad_d  = frame_bad;
                end
            end

            if (s_axis_tlast) begin
                count_d = 3'd0;
                err_d   = 1'b0;
                // Runt: too short to even contain an FCS, nothing was emitted.
                if (!full) begin
                    bad_d = 1'b1;
                end
            end else begin
                err_d = err_q || s_axis_tuser;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FCS_BYTES; i++) begin
                dly_q[i] <= '0;
            end
            count_q  <= 3'd0;
            err_q    <= 1'b0;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            mlast_q  <= 1'b0;
            muser_q  <= 1'b0;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            dly_q    <= dly_d;
            count_q  <= count_d;
            err_q    <= err_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
            mlast_q  <= mlast_d;
            muser_q  <= muser_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
        end
    end

    assign m_axis_tdata  = mdata_q;
    assign m_axis_tvalid = mvalid_q;
    assign m_axis_tlast  = mlast_q;
    assign m_axis_tuser  = muser_q;
    assign o_frame_good  = good_q;
    assign o_frame_bad   = bad_q;

endmodule

// File: tb/tb_eth_fcs_checker.sv
module tb_eth_fcs_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic       s_tlast = 1'b0;
    logic       s_tuser = 1'b0;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       m_tlast;
    logic       m_tuser;
    logic       o_good;
    logic       o_bad;

    always #5 clk = ~clk;

    eth_fcs_checker dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .o_frame_good  (o_good),
        .o_frame_bad   (o_bad)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    int checks = 0;
    int errors = 0;

    // Observations recorded by the monitor; tests compare them.
    beat_t obs_q[$];
    bit    stat_q[$];
    int    stat_cyc_q[$];
    int    tlast_cyc_q[$];
    int    cyc = 0;
    int    inv_viol = 0;
    int    hold_viol = 0;
    int    both_viol = 0;
    int    mcount = 0;

    // Expectations produced by the reference model.
    beat_t exp_q[$];
    bit    expst_q[$];

    int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
    logic [7:0] ref_frm[$];

    // Downstream ready driver.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: samples on the falling edge; a handshake seen here completes
    // on the next rising edge.
    logic [10:0] prev_out = '0;
    bit          prev_stall = 0;
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mcount     = 0;
            prev_stall = 0;
        end else begin
            if (o_good || o_bad) begin
                stat_q.push_back(o_good);
                stat_cyc_q.push_back(cyc);
                if (o_good && o_bad) both_viol++;
            end
            if (prev_stall && {m_tvalid, m_tdata, m_tlast, m_tuser} !== prev_out) hold_viol++;
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tvalid, m_tdata, m_tlast, m_tuser};
            if (mcount == 4 && m_tvalid && !m_tready && s_tready) inv_viol++;
            if (m_tvalid && m_tready) obs_q.push_back('{data: m_tdata, last: m_tlast, user: m_tuser});
            if (s_tvalid && s_tready) begin
                if (s_tlast) begin
                    mcount = 0;
                    tlast_cyc_q.push_back(cyc);
                end else if (mcount < 4) begin
                    mcount++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Textbook Ethernet CRC-32 over a whole message.
    function automatic logic [31:0] crc32_ref(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic expect_frame(input logic [7:0] b[$], input int err_idx);
        logic [7:0]  p[$];
        logic [31:0] fcs;
        bit          good;
        int          n = b.size();
        if (n <= 4) begin
            expst_q.push_back(1'b0);
            return;
        end
        for (int i = 0; i < n - 4; i++) p.push_back(b[i]);
        fcs  = {b[n-1], b[n-2], b[n-3], b[n-4]};
        good = (crc32_ref(p) == fcs) && !(err_idx >= 0 && err_idx < n);
        for (int i = 0; i < n - 4; i++)
            exp_q.push_back('{data: p[i], last: (i == n - 5), user: (i == n - 5) && !good});
        expst_q.push_back(good);
    endtask

    // ---------------- drivers ----------------
    task automatic send_frame(input logic [7:0] b[$], input int err_idx, input int gap_pct,
                              input bit with_last);
        int n;
        for (int i = 0; i < b.size(); i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = b[i];
            s_tlast  = with_last && (i == b.size() - 1);
            s_tuser  = (i == err_idx);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_tready && n < 500);
            checks++;
            if (!s_tready) begin
                errors++;
                $display("FAIL s_tready_timeout: byte %0d never accepted, s_tready=%b required 1", i, s_tready);
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((obs_q.size() < exp_q.size() || stat_q.size() < expst_q.size()) && n < 400) begin
            @(posedge clk);
            n++;
        end
        ok = (n < 400);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic start_test(input int mode);
        rdy_mode = mode;
        obs_q.delete(); stat_q.delete(); stat_cyc_q.delete(); tlast_cyc_q.delete();
        exp_q.delete(); expst_q.delete();
        inv_viol = 0; hold_viol = 0; both_viol = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata, o_good, o_bad} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b u=%b d=%h g=%b b=%b required all 0",
                     m_tvalid, m_tlast, m_tuser, m_tdata, o_good, o_bad);
        end
        checks++;
        if (s_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready: s_tready=%b required 0 during reset", s_tready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_tready: s_tready=%b required 1", s_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_good_frame();
        bit ok;
        start_test(0);
        expect_frame(ref_frm, -1);
        send_frame(ref_frm, -1, 0, 1);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL good_timeout: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
        checks++;
        if (obs_q.size() != 9) begin errors++; $display("FAIL good_count: got %0d beats required 9", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (stat_q.size() != 1 || stat_q[0] !== 1'b1) begin
            errors++; $display("FAIL good_status: got %0d pulses first=%b required one good pulse", stat_q.size(), stat_q.size() > 0 ? stat_q[0] : 1'b0);
        end
        checks++;
        if (stat_cyc_q.size() != 1 || tlast_cyc_q.size() != 1 || stat_cyc_q[0] != tlast_cyc_q[0] + 1) begin
            errors++; $display("FAIL good_status_timing: status cycles %0d tlast cycles %0d required pulse one cycle after tlast", stat_cyc_q.size(), tlast_cyc_q.size());
        end
    endtask

    task automatic test_bad_fcs();
        bit ok;
        logic [7:0] f[$];
        f = ref_frm;
        f[f.size()-1] = 8'hCA;
        start_test(0);
        expect_frame(f, -1);
        send_frame(f, -1, 0, 1);
        drain(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL badfcs_count: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL badfcs_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (stat_q.size() != 1 || stat_q[0] !== 1'b0) begin
            errors++; $display("FAIL badfcs_status: got %0d pulses required one bad pulse", stat_q.size());
        end
        checks++;
        if (both_viol != 0) begin errors++; $display("FAIL badfcs_both: good and bad together %0d times required 0", both_viol); end
    endtask

    task automatic test_runt();
        bit ok;
        logic [7:0] r[$];
        r = '{8'hAA, 8'hBB, 8'hCC};
        start_test(0);
        expect_frame(r, -1);
        expect_frame(ref_frm, -1);
        send_frame(r, -1, 0, 1);
        send_frame(ref_frm, -1, 0, 1);
        drain(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL runt_count: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL runt_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (stat_q.size() != 2 || stat_q[0] !== 1'b0 || stat_q[1] !== 1'b1) begin
            errors++; $display("FAIL runt_status: got %0d pulses required bad then good", stat_q.size());
        end
        checks++;
        if (stat_cyc_q.size() < 1 || tlast_cyc_q.size() < 1 || stat_cyc_q[0] != tlast_cyc_q[0] + 1) begin
            errors++; $display("FAIL runt_timing: status pulse not one cycle after runt tlast (pulses %0d)", stat_cyc_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        start_test(1);
        expect_frame(ref_frm, -1);
        send_frame(ref_frm, -1, 0, 1);
        drain(ok);
        rdy_mode = 0;
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (inv_viol != 0) begin errors++; $display("FAIL bp_tready: s_tready high while full and stalled %0d times required 0", inv_viol); end
        checks++;
        if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: output changed under stall %0d times required 0", hold_viol); end
        checks++;
        if (stat_q.size() != 1 || stat_q[0] !== 1'b1) begin errors++; $display("FAIL bp_status: got %0d pulses required one good", stat_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_test(0);
        expect_frame(ref_frm, -1);
        expect_frame(ref_frm, 4);
        send_frame(ref_frm, -1, 0, 1);
        send_frame(ref_frm, 4, 0, 1);
        drain(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (stat_q.size() != 2 || stat_q[0] !== 1'b1 || stat_q[1] !== 1'b0) begin
            errors++; $display("FAIL b2b_status: got %0d pulses required good then bad", stat_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [7:0] part[$];
        part = '{8'h31, 8'h32, 8'h33};
        start_test(0);
        expect_frame(ref_frm, -1);
        send_frame(part, -1, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send_frame(ref_frm, -1, 0, 1);
        drain(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (stat_q.size() != 1 || stat_q[0] !== 1'b1) begin errors++; $display("FAIL rstmid_status: got %0d pulses required one good", stat_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        start_test(2);
        for (int f = 0; f < 30; f++) begin
            logic [7:0]  b[$];
            logic [31:0] c;
            int          plen = $urandom_range(0, 16);
            int          err_idx = -1;
            for (int i = 0; i < plen; i++) b.push_back(8'($urandom));
            c = crc32_ref(b);
            b.push_back(c[7:0]); b.push_back(c[15:8]); b.push_back(c[23:16]); b.push_back(c[31:24]);
            if ($urandom_range(0, 99) < 30) begin
                int k = $urandom_range(0, b.size() - 1);
                b[k] = b[k] ^ (8'h01 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 99) < 15) err_idx = $urandom_range(0, b.size() - 1);
            expect_frame(b, err_idx);
            send_frame(b, err_idx, 30, 1);
        end
        drain(ok);
        rdy_mode = 0;
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d beats required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (stat_q.size() != expst_q.size()) begin errors++; $display("FAIL rand_status_count: got %0d required %0d", stat_q.size(), expst_q.size()); end
        for (int i = 0; i < stat_q.size() && i < expst_q.size(); i++) begin
            checks++;
            if (stat_q[i] !== expst_q[i]) begin errors++; $display("FAIL rand_status%0d: got good=%b required good=%b", i, stat_q[i], expst_q[i]); end
        end
        checks++;
        if (inv_viol != 0 || hold_viol != 0 || both_viol != 0) begin
            errors++; $display("FAIL rand_protocol: tready=%0d hold=%0d both=%0d violations required 0", inv_viol, hold_viol, both_viol);
        end
    endtask

    initial begin
        ref_frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                    8'h26, 8'h39, 8'hF4, 8'hCB};
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_runt();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
